// File: rtl/wishbone_manager.sv
`default_nettype none
// ============================================================================
//  Module   : wishbone_manager
//  Purpose  : Single-outstanding Wishbone B4 classic-cycle initiator. Turns a
//             one-cycle READ_I/WRITE_I request pulse into a held CYC/STB bus
//             cycle and reports completion with a one-cycle DONE_O strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, nRST            clock, synchronous active-low reset
//    READ_I, WRITE_I      request pulses (write wins if both are high)
//    ADR_I, CPU_DAT_I,    request address, write data and byte enables
//    SEL_I
//    CPU_DAT_O            data returned by the most recent read
//    BUSY_O               a bus cycle is in flight
//    DONE_O, ERR_O        completion strobe; ERR_O flags a timeout abort
//    ADR_O, DAT_O, SEL_O, Wishbone initiator outputs
//    WE_O, STB_O, CYC_O
//    DAT_I, ACK_I         Wishbone read data and acknowledge
//  Configuration
//    WB_MANAGER_TIMEOUT_EN  when defined, a cycle whose ACK_I has not arrived
//                           within TIMEOUT_CYCLES cycles is aborted with ERR_O.
// ============================================================================
module wishbone_manager #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  READ_I,
    input  logic                  WRITE_I,
    input  logic [ADDR_WIDTH-1:0] ADR_I,
    input  logic [31:0]           CPU_DAT_I,
    input  logic [3:0]            SEL_I,
    output logic [31:0]           CPU_DAT_O,
    output logic                  BUSY_O,
    output logic                  DONE_O,
    output logic                  ERR_O,
    output logic [ADDR_WIDTH-1:0] ADR_O,
    output logic [31:0]           DAT_O,
    output logic [3:0]            SEL_O,
    output logic                  WE_O,
    output logic                  STB_O,
    output logic                  CYC_O,
    input  logic [31:0]           DAT_I,
    input  logic                  ACK_I
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q,   adr_d;
    logic [31:0]           dat_q,   dat_d;
    logic [3:0]            sel_q,   sel_d;
    logic                  we_q,    we_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  done_q,  done_d;
    logic                  err_q,   err_d;

`ifdef WB_MANAGER_TIMEOUT_EN
    // Counter is at least 8 bits, wider only if the timeout needs it.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // Timeout disabled: the parameter is intentionally unused.
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES < 2);
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef WB_MANAGER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // Requests are accepted here, including in the DONE_O
                // cycle, which gives one idle bus cycle between transfers.
                if (READ_I || WRITE_I) begin
                    adr_d   = ADR_I;
                    dat_d   = CPU_DAT_I;
                    sel_d   = SEL_I;
                    we_d    = WRITE_I;
                    state_d = S_REQ;
`ifdef WB_MANAGER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            S_REQ: begin
                // ACK takes priority over a timeout landing on the same edge.
                if (ACK_I) begin
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = DAT_I;
                    end
`ifdef WB_MANAGER_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef WB_MANAGER_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // CYC, STB and BUSY are all exactly "in REQ", decoded from the state flop.
    assign CYC_O     = (state_q == S_REQ);
    assign STB_O     = (state_q == S_REQ);
    assign BUSY_O    = (state_q == S_REQ);
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign SEL_O     = sel_q;
    assign WE_O      = we_q;
    assign CPU_DAT_O = rdata_q;
    assign DONE_O    = done_q;
    assign ERR_O     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wishbone_manager
//  Purpose  : Self-checking bench for wishbone_manager. A transaction-level
//             reference tracks the outstanding bus cycle and is compared with
//             every DUT output on each falling edge; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_manager;

    localparam int AW = 32;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          READ_I, WRITE_I, ACK_I;
    logic [AW-1:0] ADR_I;
    logic [31:0]   CPU_DAT_I, DAT_I;
    logic [3:0]    SEL_I;
    logic [31:0]   CPU_DAT_O, DAT_O;
    logic          BUSY_O, DONE_O, ERR_O, WE_O, STB_O, CYC_O;
    logic [AW-1:0] ADR_O;
    logic [3:0]    SEL_O;

    int vectors     = 0;
    int miscompares = 0;
    bit armed       = 1'b0;

    wishbone_manager #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .nRST(nRST), .READ_I(READ_I), .WRITE_I(WRITE_I),
        .ADR_I(ADR_I), .CPU_DAT_I(CPU_DAT_I), .SEL_I(SEL_I),
        .CPU_DAT_O(CPU_DAT_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERR_O(ERR_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
        .STB_O(STB_O), .CYC_O(CYC_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference: one outstanding transaction record plus completion flags.
    // ------------------------------------------------------------------
    bit          m_active, m_we, m_done, m_err;
    logic [31:0] m_adr, m_dat, m_rdata;
    logic [3:0]  m_sel;
    int          m_waited;   // cycles the current request has been on the bus

    always @(posedge CLK) begin
        if (!nRST) begin
            m_active <= 0; m_we <= 0; m_done <= 0; m_err <= 0;
            m_adr <= 0; m_dat <= 0; m_sel <= 0; m_rdata <= 0; m_waited <= 0;
        end else begin
            m_done <= 0;
            m_err  <= 0;
            if (!m_active) begin
                if (READ_I || WRITE_I) begin
                    m_active <= 1; m_we <= WRITE_I; m_waited <= 0;
                    m_adr <= ADR_I; m_dat <= CPU_DAT_I; m_sel <= SEL_I;
                end
            end else if (ACK_I) begin
                m_active <= 0; m_we <= 0; m_done <= 1;
                if (!m_we) m_rdata <= DAT_I;
            end
`ifdef WB_MANAGER_TIMEOUT_EN
            else if (m_waited + 1 == TO) begin
                m_active <= 0; m_we <= 0; m_done <= 1; m_err <= 1;
            end
`endif
            else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    // Single compare process against the reference, every falling edge.
    always @(negedge CLK) begin
        if (armed) begin
            vectors++;
            if ({CYC_O, STB_O, BUSY_O, WE_O, DONE_O, ERR_O} !==
                    {m_active, m_active, m_active, m_we, m_done, m_err} ||
                ADR_O !== m_adr || DAT_O !== m_dat || SEL_O !== m_sel ||
                CPU_DAT_O !== m_rdata) begin
                miscompares++;
                $display("FAIL model t=%0t got cyc/stb/busy/we/done/err=%b%b%b%b%b%b adr=%h dat=%h sel=%h rd=%h required %b%b%b%b%b%b adr=%h dat=%h sel=%h rd=%h",
                         $time, CYC_O, STB_O, BUSY_O, WE_O, DONE_O, ERR_O,
                         ADR_O, DAT_O, SEL_O, CPU_DAT_O,
                         m_active, m_active, m_active, m_we, m_done, m_err,
                         m_adr, m_dat, m_sel, m_rdata);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    // cyc,stb,busy,we,done,err packed for compact literal checks
    function automatic logic [31:0] ctl();
        return {26'd0, CYC_O, STB_O, BUSY_O, WE_O, DONE_O, ERR_O};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 0; READ_I = 0; WRITE_I = 0; ACK_I = 0;
        ADR_I = 0; CPU_DAT_I = 0; SEL_I = 0; DAT_I = 0;

        // Reset held for two cycles
        tick(); armed = 1'b1;
        tick();
        chk("reset_ctl", ctl(), 32'h0);
        chk("reset_adr", ADR_O, 32'h0);
        chk("reset_rd",  CPU_DAT_O, 32'h0);
        nRST = 1;

        // Write with ack after 3 cycles
        WRITE_I = 1; ADR_I = 32'h3000_0010; CPU_DAT_I = 32'hDEAD_BEEF; SEL_I = 4'hF;
        tick();
        WRITE_I = 0; ADR_I = 0; CPU_DAT_I = 0; SEL_I = 0;
        chk("wr_start_ctl", ctl(), 32'b111100);
        chk("wr_adr", ADR_O, 32'h3000_0010);
        chk("wr_dat", DAT_O, 32'hDEAD_BEEF);
        chk("wr_sel", {28'd0, SEL_O}, 32'hF);
        tick(); tick();
        chk("wr_hold_ctl", ctl(), 32'b111100);
        ACK_I = 1;
        tick();
        ACK_I = 0;
        chk("wr_done_ctl", ctl(), 32'b000010);
        chk("wr_adr_kept", ADR_O, 32'h3000_0010);
        tick();
        chk("wr_done_once", ctl(), 32'b000000);

        // Read returning DEADBEEF
        READ_I = 1; ADR_I = 32'h3000_0010;
        tick();
        READ_I = 0;
        chk("rd_start_ctl", ctl(), 32'b111000);
        tick();
        DAT_I = 32'hDEAD_BEEF; ACK_I = 1;
        tick();
        ACK_I = 0; DAT_I = 0;
        chk("rd_done_ctl", ctl(), 32'b000010);
        chk("rd_data", CPU_DAT_O, 32'hDEAD_BEEF);

        // Back-to-back: request in the DONE cycle
        READ_I = 1; ADR_I = 32'h0000_0040; SEL_I = 4'h3;
        tick();
        READ_I = 0;
        chk("b2b_ctl", ctl(), 32'b111000);
        chk("b2b_adr", ADR_O, 32'h0000_0040);
        // Write while busy must be ignored
        WRITE_I = 1; ADR_I = 32'h0000_0099; CPU_DAT_I = 32'h1111_1111;
        tick();
        WRITE_I = 0;
        chk("busy_ign_adr", ADR_O, 32'h0000_0040);
        chk("busy_ign_ctl", ctl(), 32'b111000);
        DAT_I = 32'h1234_5678; ACK_I = 1;
        tick();
        ACK_I = 0; DAT_I = 0;
        chk("b2b_rd_data", CPU_DAT_O, 32'h1234_5678);
        tick();
        chk("no_queued_txn", ctl(), 32'b000000);

        // Both requests high: write wins
        READ_I = 1; WRITE_I = 1; ADR_I = 32'h0000_0050; CPU_DAT_I = 32'hCAFE_F00D; SEL_I = 4'h1;
        tick();
        READ_I = 0; WRITE_I = 0;
        chk("both_ctl", ctl(), 32'b111100);
        chk("both_sel", {28'd0, SEL_O}, 32'h1);
        DAT_I = 32'h5555_5555; ACK_I = 1;
        tick();
        ACK_I = 0; DAT_I = 0;
        chk("wr_rd_unchanged", CPU_DAT_O, 32'h1234_5678);
        tick();
        // ACK in IDLE ignored
        ACK_I = 1; DAT_I = 32'h7777_7777;
        tick();
        ACK_I = 0; DAT_I = 0;
        chk("idle_ack_ctl", ctl(), 32'b000000);
        chk("idle_ack_rd", CPU_DAT_O, 32'h1234_5678);

        // Long wait without ack
        READ_I = 1; ADR_I = 32'h0000_0070;
        tick();
        READ_I = 0;
        for (int i = 0; i < 20; i++) tick();
`ifdef WB_MANAGER_TIMEOUT_EN
        chk("long_wait_timed_out", ctl(), 32'b000000);
`else
        chk("long_wait_ctl", ctl(), 32'b111000);
`endif

        // Reset while waiting in REQ
        if (!CYC_O) begin
            READ_I = 1; ADR_I = 32'h0000_0060;
            tick();
            READ_I = 0;
        end
        tick();
        chk("pre_rst_cyc", ctl(), 32'b111000);
        nRST = 0;
        tick();
        nRST = 1;
        chk("mid_rst_ctl", ctl(), 32'b000000);
        chk("mid_rst_rd", CPU_DAT_O, 32'h0);
        ACK_I = 1; DAT_I = 32'h0000_FFFF;
        tick();
        ACK_I = 0; DAT_I = 0;
        chk("post_rst_ack", ctl(), 32'b000000);
        chk("post_rst_rd", CPU_DAT_O, 32'h0);

`ifdef WB_MANAGER_TIMEOUT_EN
        // Timeout: DONE/ERR 8 cycles after STB rose
        READ_I = 1; ADR_I = 32'h0000_0080;
        tick();
        READ_I = 0;
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_pending", ctl(), 32'b111000);
        tick();
        chk("to_fire", ctl(), 32'b000011);
        chk("to_rd_kept", CPU_DAT_O, 32'h0);
        // Ack on the timeout edge wins
        READ_I = 1;
        tick();
        READ_I = 0;
        for (int i = 0; i < TO - 1; i++) tick();
        ACK_I = 1; DAT_I = 32'hA5A5_A5A5;
        tick();
        ACK_I = 0; DAT_I = 0;
        chk("to_ack_wins", ctl(), 32'b000010);
        chk("to_ack_data", CPU_DAT_O, 32'hA5A5_A5A5);
`endif
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wishbone_manager.md
Name: wishbone_manager

Overview:
- Single-outstanding Wishbone B4 classic-cycle initiator.
- Lets a team project (or an on-chip test engine) issue 32-bit reads/writes as an additional manager port on wishbone_arbitrator.
- Converts a simple one-cycle request pulse interface into a held CYC/STB bus cycle, then returns read data plus a one-cycle DONE_O completion strobe.

Parameters:
- ADDR_WIDTH, 32, width of ADR_I/ADR_O.
- TIMEOUT_CYCLES, 255, cycles to wait for ACK_I before aborting. Used only with WB_MANAGER_TIMEOUT_EN; minimum 2.

Ports:
- CLK  input  1  bus clock (wb_clk_i domain).
- nRST  input  1  reset; synchronous, active-low.
- READ_I  input  1  request pulse; start a read.
- WRITE_I  input  1  request pulse; start a write.
- ADR_I  input  ADDR_WIDTH  request byte address.
- CPU_DAT_I  input  32  write data.
- SEL_I  input  4  byte enables.
- CPU_DAT_O  output  32  last read data.
- BUSY_O  output  1  transaction in flight.
- DONE_O  output  1  one-cycle completion strobe.
- ERR_O  output  1  completion was a timeout (valid with DONE_O).
- ADR_O  output  ADDR_WIDTH  Wishbone address.
- DAT_O  output  32  Wishbone write data.
- SEL_O  output  4  Wishbone byte select.
- WE_O  output  1  Wishbone write enable.
- STB_O  output  1  Wishbone strobe.
- CYC_O  output  1  Wishbone cycle.
- DAT_I  input  32  Wishbone read data.
- ACK_I  input  1  Wishbone acknowledge.

Behaviour:
- Reset: nRST sampled low at a CLK rising edge. All outputs are registered and reset to 0. State returns to IDLE. Reset mid-transaction abandons the cycle: CYC_O/STB_O are low after that edge and DONE_O does not pulse.
- FSM states: IDLE and REQ.
- IDLE, READ_I or WRITE_I high:
  - Latch ADR_I, CPU_DAT_I, SEL_I and the direction into ADR_O/DAT_O/SEL_O/WE_O.
  - Assert CYC_O=STB_O=1 and BUSY_O=1 at the next edge; go to REQ.
  - Latency from request to STB_O is 1 cycle.
- Both READ_I and WRITE_I high in the same cycle: write wins.
- REQ:
  - ADR_O/DAT_O/SEL_O/WE_O/CYC_O/STB_O are held stable until ACK_I is sampled high.
  - Wait time is unbounded when the macro is off.
- REQ, ACK_I sampled high at edge k:
  - Next cycle: CYC_O=STB_O=WE_O=0, BUSY_O=0, DONE_O=1, ERR_O=0; state IDLE.
  - Read: CPU_DAT_O <= DAT_I captured at edge k.
  - Write: CPU_DAT_O is unchanged.
- DONE_O is high for exactly one cycle.
- A request presented in the DONE_O cycle is accepted. Back-to-back transfers therefore have CYC_O low for exactly 1 cycle.
- READ_I/WRITE_I while BUSY_O=1 are ignored: no queueing, no side effects.
- ACK_I while in IDLE is ignored.
- ADR_O, DAT_O and SEL_O keep their last values after completion. Only CYC_O, STB_O and WE_O return to 0.
- No bursts, no retries, no ERR_I/RTY_I inputs.

Optional Feature:
- Macro: WB_MANAGER_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without ACK_I.
  - When it reaches TIMEOUT_CYCLES-1 with no ACK_I, at the next edge: CYC_O=STB_O=0, BUSY_O=0, DONE_O=1, ERR_O=1, CPU_DAT_O unchanged; state IDLE.
  - If ACK_I arrives on the same edge as the timeout, the ACK wins (ERR_O=0).
- Undefined: no counter; ERR_O is tied to 0.

Test Plan:
- Reset, then hold nRST=0 for 2 cycles → all outputs 0. Then pulse WRITE_I, ADR_I=0x3000_0010, CPU_DAT_I=0xDEADBEEF, SEL_I=0xF → next cycle CYC_O=STB_O=WE_O=1 with those values. Slave acks after 3 cycles → DONE_O one cycle later for 1 cycle, CYC_O=0.
- Pulse READ_I at 0x3000_0010; slave returns DAT_I=0xDEADBEEF with ACK_I → CPU_DAT_O=0xDEADBEEF and DONE_O=1 on the same cycle; WE_O=0 throughout.
- Back-to-back: pulse READ_I in the DONE_O cycle → CYC_O low for exactly 1 cycle. Pulse WRITE_I while BUSY_O=1 → no second transaction, ADR_O unchanged.
- READ_I and WRITE_I both high → write cycle (WE_O=1). ACK_I pulsed in IDLE → no DONE_O, no state change.
- Drop nRST for 1 cycle while waiting in REQ → CYC_O=STB_O=0 after that edge, DONE_O stays 0. A later ACK_I is ignored.
- With WB_MANAGER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks → DONE_O=ERR_O=1 with CYC_O=0, 8 cycles after STB_O rose. Repeat with ACK_I on the timeout edge → ERR_O=0.
